// File: rtl/clock_disp_pkg.sv
// rtl/clock_disp_pkg.sv - shared constants, segment patterns and scan FSM states for the digit latch scanner
package clock_disp_pkg;

  localparam int NUM_DIGITS = 6;

  // Segment patterns, {a,b,c,d,e,f,g}, active high
  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, NEXT} scan_state_e;

  typedef enum logic [2:0] {D_HT, D_HO, D_MT, D_MO, D_ST, D_SO} digit_idx_e;

  // Digit 0 (Ht) sits in the top nibble of the packed word
  function automatic logic [3:0] digit_of(input logic [23:0] d, input int i);
    return d[4*(NUM_DIGITS-1-i) +: 4];
  endfunction

  function automatic logic [2:0] first_dirty(input logic [NUM_DIGITS-1:0] m);
    logic [2:0] r;
    r = '0;
    for (int i = NUM_DIGITS-1; i >= 0; i--) begin
      if (m[i]) r = 3'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// rtl/bcd_to_seg7.sv - combinational BCD to {a..g} decoder, codes above 9 are blank
module bcd_to_seg7
  import clock_disp_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/digit_latch_scanner.sv
// rtl/digit_latch_scanner.sv - writes changed BCD digits onto a shared segment bus with one latch strobe per digit
// Define SCAN_LZB_EN to blank a leading zero in the Ht slot under lzb_i.
module digit_latch_scanner
  import clock_disp_pkg::*;
#(
  parameter int STROBE_LEN    = 1,
  parameter int REFRESH_SCANS = 60
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] digits_i,
  input  logic        update_i,
  input  logic        force_i,
  input  logic        lzb_i,
  output logic [6:0]  seg_o,
  output logic [5:0]  le_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam int STB_W = (STROBE_LEN > 1) ? $clog2(STROBE_LEN) : 1;
  localparam int CNT_W = (REFRESH_SCANS > 1) ? $clog2(REFRESH_SCANS) : 1;

  scan_state_e           state_q, state_d;
  logic [23:0]           scan_q, scan_d, shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0] mask_q, mask_d, dirty, rest;
  logic [2:0]            idx_q, idx_d;
  logic [STB_W-1:0]      stb_cnt_q, stb_cnt_d;
  logic [CNT_W-1:0]      refresh_cnt_q, refresh_cnt_d;
  logic                  shadow_vld_q, shadow_vld_d;
  logic                  pend_q, pend_d, pend_force_q, pend_force_d;
  logic                  accept, finish, full, busy, lzb_dirty, blank;
  logic [3:0]            cur_digit, enc_bcd;
  logic [6:0]            enc_seg;

`ifdef SCAN_LZB_EN
  logic scan_lzb_q, scan_lzb_d, shadow_lzb_q, shadow_lzb_d;

  always_comb begin
    scan_lzb_d   = accept ? lzb_i : scan_lzb_q;
    shadow_lzb_d = finish ? scan_lzb_q : shadow_lzb_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_lzb_q   <= 1'b0;
      shadow_lzb_q <= 1'b0;
    end else begin
      scan_lzb_q   <= scan_lzb_d;
      shadow_lzb_q <= shadow_lzb_d;
    end
  end

  assign lzb_dirty = lzb_i != shadow_lzb_q;
  assign blank     = scan_lzb_q && (idx_q == D_HT) && (cur_digit == 4'd0);
`else
  logic unused_lzb;
  assign unused_lzb = lzb_i;
  assign lzb_dirty  = 1'b0;
  assign blank      = 1'b0;
`endif

  // Code 4'hF decodes to blank, which lets leading-zero blanking reuse the decoder
  assign cur_digit = digit_of(scan_q, int'(idx_q));
  assign enc_bcd   = blank ? 4'hF : cur_digit;

  bcd_to_seg7 u_enc (
    .bcd_i (enc_bcd),
    .seg_o (enc_seg)
  );

  always_comb begin
    dirty = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      dirty[i] = digit_of(digits_i, i) != digit_of(shadow_q, i);
    end
    dirty[D_HT] = dirty[D_HT] | lzb_dirty;
  end

  always_comb begin
    state_d       = state_q;
    scan_d        = scan_q;
    shadow_d      = shadow_q;
    mask_d        = mask_q;
    idx_d         = idx_q;
    stb_cnt_d     = stb_cnt_q;
    refresh_cnt_d = refresh_cnt_q;
    shadow_vld_d  = shadow_vld_q;
    pend_d        = pend_q;
    pend_force_d  = pend_force_q;
    accept        = 1'b0;
    finish        = 1'b0;
    full          = 1'b0;
    rest          = mask_q & ~(NUM_DIGITS'(1) << idx_q);
    busy          = (state_q != IDLE);
    seg_o         = '0;
    le_o          = '0;
    done_o        = 1'b0;

    case (state_q)
      IDLE: begin
        if (update_i || force_i || pend_q) begin
          accept = 1'b1;
          full   = !shadow_vld_q || force_i || pend_force_q ||
                   (refresh_cnt_q == CNT_W'(REFRESH_SCANS-1));
          mask_d  = full ? '1 : dirty;
          idx_d   = first_dirty(mask_d);
          state_d = (mask_d != '0) ? SETUP : NEXT;
          scan_d  = digits_i;
          pend_d       = 1'b0;
          pend_force_d = 1'b0;
          if (refresh_cnt_q == CNT_W'(REFRESH_SCANS-1)) refresh_cnt_d = '0;
          else                                           refresh_cnt_d = refresh_cnt_q + CNT_W'(1);
        end
      end
      SETUP: begin
        seg_o     = enc_seg;
        stb_cnt_d = '0;
        state_d   = STROBE;
      end
      STROBE: begin
        seg_o = enc_seg;
        le_o  = 6'b1 << idx_q;
        if (stb_cnt_q == STB_W'(STROBE_LEN-1)) state_d = HOLD;
        else                                   stb_cnt_d = stb_cnt_q + STB_W'(1);
      end
      HOLD: begin
        seg_o  = enc_seg;
        mask_d = rest;
        if (rest != '0) begin
          idx_d   = first_dirty(rest);
          state_d = SETUP;
        end else begin
          done_o  = 1'b1;
          finish  = 1'b1;
          state_d = IDLE;
        end
      end
      NEXT: begin
        done_o  = 1'b1;
        finish  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (finish) begin
      shadow_d     = scan_q;
      shadow_vld_d = 1'b1;
    end
    // Requests during a scan merge into a single queued scan; force stays sticky
    if (busy && (update_i || force_i)) begin
      pend_d       = 1'b1;
      pend_force_d = pend_force_q | force_i;
    end
  end

  assign busy_o = busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      scan_q        <= '0;
      shadow_q      <= '0;
      mask_q        <= '0;
      idx_q         <= '0;
      stb_cnt_q     <= '0;
      refresh_cnt_q <= '0;
      shadow_vld_q  <= 1'b0;
      pend_q        <= 1'b0;
      pend_force_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      scan_q        <= scan_d;
      shadow_q      <= shadow_d;
      mask_q        <= mask_d;
      idx_q         <= idx_d;
      stb_cnt_q     <= stb_cnt_d;
      refresh_cnt_q <= refresh_cnt_d;
      shadow_vld_q  <= shadow_vld_d;
      pend_q        <= pend_d;
      pend_force_q  <= pend_force_d;
    end
  end

endmodule

// File: tb/tb_digit_latch_scanner.sv
// tb/tb_digit_latch_scanner.sv - self-checking bench for digit_latch_scanner against a digit-level scan model
module tb_digit_latch_scanner;

  localparam int RS = 3;
`ifdef SCAN_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] digits_i = '0;
  logic        update_i = 1'b0;
  logic        force_i = 1'b0;
  logic        lzb_i = 1'b0;
  logic [6:0]  seg_o;
  logic [5:0]  le_o;
  logic        busy_o;
  logic        done_o;

  always #5 clk = ~clk;

  digit_latch_scanner #(.STROBE_LEN(1), .REFRESH_SCANS(RS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .digits_i (digits_i),
    .update_i (update_i),
    .force_i  (force_i),
    .lzb_i    (lzb_i),
    .seg_o    (seg_o),
    .le_o     (le_o),
    .busy_o   (busy_o),
    .done_o   (done_o)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [6:0] seg_tab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                               7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

  typedef struct { int idx; logic [6:0] seg; int c; } wr_t;
  wr_t obs_q[$];
  wr_t exp_q[$];
  int  done_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  logic [5:0] prev_le = '0;
  logic [6:0] prev_seg = '0;
  logic       prev_done = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      wr_t w;
      check("le_onehot", 32'($onehot0(le_o)), 1);
      if (!busy_o) begin
        check("idle_seg", 32'(seg_o), 0);
        check("idle_le", 32'(le_o), 0);
      end
      if (done_o) check("done_busy", 32'(busy_o), 1);
      if (prev_done) check("busy_drop", 32'(busy_o), 0);
      if (le_o != 0 && prev_le == 0) check("seg_setup_eq", 32'(seg_o), 32'(prev_seg));
      if (prev_le != 0) check("seg_hold_eq", 32'(seg_o), 32'(prev_seg));
      if (le_o != 0 && le_o != prev_le) begin
        w.idx = -1;
        for (int i = 0; i < 6; i++) if (le_o[i]) w.idx = i;
        w.seg = seg_o;
        w.c   = cyc;
        obs_q.push_back(w);
      end
      if (done_o) done_q.push_back(cyc);
      prev_le   <= le_o;
      prev_seg  <= seg_o;
      prev_done <= done_o;
    end else begin
      prev_le   <= '0;
      prev_seg  <= '0;
      prev_done <= 1'b0;
    end
  end

  // Reference: what the display should be told, one scan at a time
  int m_sh[6];
  bit m_vld;
  int m_cnt;
  bit m_lzb;

  function automatic int dig(input logic [23:0] d, input int i);
    return int'((d >> (20 - 4*i)) & 24'hF);
  endfunction

  task automatic model_reset();
    m_vld = 1'b0;
    m_cnt = 0;
    m_lzb = 1'b0;
  endtask

  task automatic model_scan(input logic [23:0] d, input bit frc, input bit lzb);
    bit full;
    bit blank;
    int v;
    wr_t w;
    full  = !m_vld || frc || (m_cnt == RS - 1);
    m_cnt = (m_cnt + 1) % RS;
    for (int i = 0; i < 6; i++) begin
      v     = dig(d, i);
      blank = LZB && i == 0 && lzb && v == 0;
      if (full || v != m_sh[i] || (LZB && i == 0 && lzb != m_lzb)) begin
        w.idx = i;
        w.seg = (blank || v > 9) ? 7'b0 : seg_tab[v];
        w.c   = 0;
        exp_q.push_back(w);
      end
      m_sh[i] = v;
    end
    m_lzb = lzb;
    m_vld = 1'b1;
  endtask

  task automatic compare(input string tag);
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      check({tag, "_idx"}, obs_q[k].idx, exp_q[k].idx);
      check({tag, "_seg"}, 32'(obs_q[k].seg), 32'(exp_q[k].seg));
    end
    obs_q.delete();
    exp_q.delete();
    done_q.delete();
  endtask

  task automatic pulse(input logic [23:0] d, input bit upd, input bit frc, output int t);
    @(negedge clk);
    digits_i = d;
    update_i = upd;
    force_i  = frc;
    t        = cyc;
    @(negedge clk);
    update_i = 1'b0;
    force_i  = 1'b0;
  endtask

  task automatic wait_dones(input int n);
    int b;
    b = 0;
    while (done_q.size() < n && b < 400) begin
      @(negedge clk);
      b++;
    end
    check("done_timeout", 32'(done_q.size() >= n), 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    update_i = 1'b0;
    force_i  = 1'b0;
    #1;
    check("rst_seg", 32'(seg_o), 0);
    check("rst_le", 32'(le_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_done", 32'(done_o), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    obs_q.delete();
    exp_q.delete();
    done_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t2;
    logic [23:0] cur, d2;
    bit frc, frc2, upd;

    do_reset();

    // Full first scan: strobe cadence and done position
    model_scan(24'h123456, 0, 0);
    pulse(24'h123456, 1, 0, t);
    wait_dones(1);
    for (int k = 0; k < 6; k++)
      if (k < obs_q.size()) check("t1_strobe_cyc", obs_q[k].c, t + 2 + 3*k);
    check("t1_done_cyc", done_q.size() > 0 ? done_q[0] : -1, t + 18);
    compare("t1");

    // Single changed digit
    model_scan(24'h123457, 0, 0);
    pulse(24'h123457, 1, 0, t);
    wait_dones(1);
    if (obs_q.size() > 0) check("t2_strobe_cyc", obs_q[0].c, t + 2);
    check("t2_done_cyc", done_q.size() > 0 ? done_q[0] : -1, t + 3);
    compare("t2");

    // Update during a scan is queued and served afterwards
    do_reset();
    model_scan(24'h123456, 0, 0);
    model_scan(24'h123500, 0, 0);
    pulse(24'h123456, 1, 0, t);
    repeat (4) @(negedge clk);
    pulse(24'h123500, 1, 0, t2);
    wait_dones(2);
    if (obs_q.size() > 6 && done_q.size() > 0) check("t3_pend_start", obs_q[6].c, done_q[0] + 3);
    compare("t3");

    // Refresh-forced full scan with unchanged digits
    model_scan(24'h123500, 0, 0);
    pulse(24'h123500, 1, 0, t);
    wait_dones(1);
    compare("t3r");

    // Force alone, with an out-of-range Ho code
    model_scan(24'h1C3500, 1, 0);
    pulse(24'h1C3500, 0, 1, t);
    wait_dones(1);
    compare("t4");

    // Abort mid-scan, then refresh cadence with identical digits
    pulse(24'h235959, 1, 0, t);
    repeat (5) @(negedge clk);
    do_reset();
    for (int s = 0; s < 3; s++) begin
      model_scan(24'h235959, 0, 0);
      pulse(24'h235959, 1, 0, t);
      wait_dones(1);
      if (s == 1) check("t5_empty_done", done_q.size() > 0 ? done_q[0] : -1, t + 1);
      compare("t5");
    end

    // Leading-zero blanking
    do_reset();
    lzb_i = 1'b1;
    model_scan(24'h012345, 0, 1);
    pulse(24'h012345, 1, 0, t);
    wait_dones(1);
    if (obs_q.size() > 0) check("t6_ht_seg", 32'(obs_q[0].seg), LZB ? 32'h0 : 32'h7E);
    compare("t6a");
    lzb_i = 1'b0;
    model_scan(24'h012345, 0, 0);
    pulse(24'h012345, 1, 0, t);
    wait_dones(1);
    compare("t6b");

    // Randomised traffic
    do_reset();
    cur = 24'h000000;
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < 6; i++)
        if ($urandom_range(0, 1) == 1) cur[20 - 4*i +: 4] = 4'($urandom_range(0, 15));
      frc = ($urandom_range(0, 5) == 0);
      upd = frc ? 1'($urandom_range(0, 1)) : 1'b1;
      if ($urandom_range(0, 3) == 0) lzb_i = ~lzb_i;
      model_scan(cur, frc, lzb_i);
      pulse(cur, upd, frc, t);
      if ($urandom_range(0, 2) == 0) begin
        d2 = cur;
        d2[20 - 4*$urandom_range(0, 5) +: 4] = 4'($urandom_range(0, 9));
        frc2 = ($urandom_range(0, 4) == 0);
        repeat ($urandom_range(0, 8)) @(negedge clk);
        model_scan(d2, frc2, lzb_i);
        pulse(d2, 1, frc2, t2);
        cur = d2;
        wait_dones(2);
      end else begin
        wait_dones(1);
      end
      compare("rnd");
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
